// File: rtl/l15_tag_ctrl.sv
// L1.5 I-cache tag-store front end: arbitrates invalidate sweeps, refill writes
// and lookup reads onto the tag SCM. Lookup hit/miss is reported one cycle after
// the grant.
module l15_tag_ctrl #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned TAG_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_req_i,
   output logic                  flush_ack_o,
   output logic                  busy_o,
   input  logic                  lookup_req_i,
   input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
   input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
   output logic                  lookup_gnt_o,
   output logic                  lookup_rvalid_o,
   output logic                  lookup_hit_o,
   input  logic                  refill_req_i,
   input  logic [ADDR_WIDTH-1:0] refill_addr_i,
   input  logic [TAG_WIDTH-1:0]  refill_tag_i,
   output logic                  refill_gnt_o,
   output logic                  tag_req_o,
   output logic                  tag_write_o,
   output logic [ADDR_WIDTH-1:0] tag_addr_o,
   output logic [TAG_WIDTH:0]    tag_wdata_o,
   input  logic [TAG_WIDTH:0]    tag_rdata_i
);

   localparam int unsigned WORD_WIDTH = TAG_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      SWEEP = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic                    rvalid_q, rvalid_d;
   logic [TAG_WIDTH-1:0]    lkp_tag_q, lkp_tag_d;
   logic                    lkp_byp_q, lkp_byp_d;
   logic [WORD_WIDTH-1:0]   byp_word_q, byp_word_d;
   logic                    wr_valid_q, wr_valid_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_WIDTH-1:0]   wr_word_q, wr_word_d;
   logic [WORD_WIDTH-1:0]   cmp_word;

   // State register and datapath flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         lkp_tag_q  <= '0;
         lkp_byp_q  <= 1'b0;
         byp_word_q <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_word_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         rvalid_q   <= rvalid_d;
         lkp_tag_q  <= lkp_tag_d;
         lkp_byp_q  <= lkp_byp_d;
         byp_word_q <= byp_word_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_word_q  <= wr_word_d;
      end
   end

   // Next state, sweep counter, arbitration and SCM command
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ack_d        = 1'b0;
      busy_o       = 1'b0;
      refill_gnt_o = 1'b0;
      lookup_gnt_o = 1'b0;
      tag_req_o    = 1'b0;
      tag_write_o  = 1'b0;
      tag_addr_o   = '0;
      tag_wdata_o  = '0;
      case (state_q)
         INIT, SWEEP: begin
            busy_o      = 1'b1;
            tag_req_o   = 1'b1;
            tag_write_o = 1'b1;
            tag_addr_o  = cnt_q;
            cnt_d       = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               ack_d   = (state_q == SWEEP);
            end
         end
         IDLE: begin
            // A flush still held during the ack cycle belongs to the sweep just finished
            if (flush_req_i && !ack_q) begin
               state_d = SWEEP;
            end else if (refill_req_i) begin
               refill_gnt_o = 1'b1;
               tag_req_o    = 1'b1;
               tag_write_o  = 1'b1;
               tag_addr_o   = refill_addr_i;
               tag_wdata_o  = {1'b1, refill_tag_i};
            end else if (lookup_req_i) begin
               lookup_gnt_o = 1'b1;
               tag_req_o    = 1'b1;
               tag_addr_o   = lookup_addr_i;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
      // Combinational outputs are quiet while reset is asserted
      if (!rst_n) begin
         busy_o       = 1'b0;
         refill_gnt_o = 1'b0;
         lookup_gnt_o = 1'b0;
         tag_req_o    = 1'b0;
         tag_write_o  = 1'b0;
         tag_addr_o   = '0;
         tag_wdata_o  = '0;
      end
   end

   // Lookup capture and last-refill bypass tracking
   always_comb begin
      rvalid_d   = lookup_gnt_o;
      lkp_tag_d  = lkp_tag_q;
      lkp_byp_d  = lkp_byp_q;
      byp_word_d = byp_word_q;
      if (lookup_gnt_o) begin
         lkp_tag_d  = lookup_tag_i;
         lkp_byp_d  = wr_valid_q && (wr_addr_q == lookup_addr_i);
         byp_word_d = wr_word_q;
      end
      // Only a refill in the immediately preceding cycle can be bypassed; sweep
      // cycles never grant a refill, so they clear the flag
      wr_valid_d = refill_gnt_o;
      wr_addr_d  = wr_addr_q;
      wr_word_d  = wr_word_q;
      if (refill_gnt_o) begin
         wr_addr_d = refill_addr_i;
         wr_word_d = tag_wdata_o;
      end
   end

   // SCM read data arrives in the result cycle, so the compare sits after it
   assign cmp_word        = lkp_byp_q ? byp_word_q : tag_rdata_i;
   assign lookup_rvalid_o = rvalid_q;
   assign lookup_hit_o    = rvalid_q & cmp_word[TAG_WIDTH] &
                            (cmp_word[TAG_WIDTH-1:0] == lkp_tag_q);
   assign flush_ack_o     = ack_q;

endmodule

// File: tb/tb_l15_tag_ctrl.sv
// Bench for l15_tag_ctrl: behavioural tag-array model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l15_tag_ctrl;

   localparam int unsigned AW = 6;
   localparam int unsigned TW = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_req_i, flush_ack_o, busy_o;
   logic          lookup_req_i, lookup_gnt_o, lookup_rvalid_o, lookup_hit_o;
   logic [AW-1:0] lookup_addr_i;
   logic [TW-1:0] lookup_tag_i;
   logic          refill_req_i, refill_gnt_o;
   logic [AW-1:0] refill_addr_i;
   logic [TW-1:0] refill_tag_i;
   logic          tag_req_o, tag_write_o;
   logic [AW-1:0] tag_addr_o;
   logic [TW:0]   tag_wdata_o;
   logic [TW:0]   tag_rdata_i;

   always #5 clk = ~clk;

   l15_tag_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
      .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
      .lookup_gnt_o(lookup_gnt_o), .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
      .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i), .refill_tag_i(refill_tag_i),
      .refill_gnt_o(refill_gnt_o),
      .tag_req_o(tag_req_o), .tag_write_o(tag_write_o), .tag_addr_o(tag_addr_o),
      .tag_wdata_o(tag_wdata_o), .tag_rdata_i(tag_rdata_i)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: no grant within bound (cycle %0d)", name, cyc);
   endtask

   // Tag SCM: unreset memory, one-cycle read latency; 'stale' corrupts a read
   // of the word refilled the cycle before, so only a bypass can still hit
   logic [TW:0]   mem [DEPTH];
   logic          stale = 1'b0;
   logic          prev_wr_v = 1'b0;
   logic [AW-1:0] prev_wr_a = '0;

   always @(posedge clk) begin
      if (tag_req_o && tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
      if (tag_req_o && !tag_write_o)
         tag_rdata_i <= (stale && prev_wr_v && prev_wr_a == tag_addr_o) ? ~mem[tag_addr_o]
                                                                       : mem[tag_addr_o];
      prev_wr_v <= tag_req_o && tag_write_o && tag_wdata_o[TW];
      prev_wr_a <= tag_addr_o;
   end

   // Reference model: sweep position (-1 when idle), ack/result pipeline, tag array
   int            m_pos = 0;
   bit            m_fsw = 1'b0;
   bit            m_ack = 1'b0;
   bit            m_pend = 1'b0;
   bit            m_phit = 1'b0;
   bit            m_valid [DEPTH];
   logic [TW-1:0] m_tag [DEPTH];
   bit            g_rgnt = 1'b0;
   bit            g_lgnt = 1'b0;

   // Single compare process: expectations for this cycle, then advance the model
   always @(negedge clk) begin : cmp_proc
      bit            e_req, e_we, e_rg, e_lg, e_fl, nhit;
      logic [AW-1:0] e_addr;
      logic [TW:0]   e_wd;
      if (!rst_n) begin
         chk("reset_outputs", 32'({flush_ack_o, busy_o, lookup_gnt_o, lookup_rvalid_o,
                                  lookup_hit_o, refill_gnt_o, tag_req_o, tag_write_o}), 32'd0);
         m_pos = 0; m_fsw = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
         g_rgnt = 1'b0; g_lgnt = 1'b0;
      end else begin
         e_req = 1'b0; e_we = 1'b0; e_rg = 1'b0; e_lg = 1'b0; e_fl = 1'b0;
         e_addr = '0; e_wd = '0;
         nhit = m_valid[lookup_addr_i] && (m_tag[lookup_addr_i] == lookup_tag_i);
         if (m_pos >= 0) begin
            e_req = 1'b1; e_we = 1'b1; e_addr = AW'(m_pos); e_wd = '0;
         end else if (flush_req_i && !m_ack) begin
            e_fl = 1'b1;
         end else if (refill_req_i) begin
            e_rg = 1'b1; e_req = 1'b1; e_we = 1'b1;
            e_addr = refill_addr_i; e_wd = {1'b1, refill_tag_i};
         end else if (lookup_req_i) begin
            e_lg = 1'b1; e_req = 1'b1; e_addr = lookup_addr_i;
         end
         chk("flush_ack", 32'(flush_ack_o), 32'(m_ack));
         chk("busy", 32'(busy_o), 32'(m_pos >= 0));
         chk("rvalid", 32'(lookup_rvalid_o), 32'(m_pend));
         if (m_pend) chk("hit", 32'(lookup_hit_o), 32'(m_phit));
         chk("refill_gnt", 32'(refill_gnt_o), 32'(e_rg));
         chk("lookup_gnt", 32'(lookup_gnt_o), 32'(e_lg));
         chk("tag_req", 32'(tag_req_o), 32'(e_req));
         chk("tag_write", 32'(tag_write_o), 32'(e_we));
         if (e_req) chk("tag_addr", 32'(tag_addr_o), 32'(e_addr));
         if (e_we) chk("tag_wdata", 32'(tag_wdata_o), 32'(e_wd));
         if (m_pos >= 0) begin
            m_valid[m_pos] = 1'b0;
            if (m_pos == DEPTH - 1) begin
               m_pos = -1;
               m_ack = m_fsw;
            end else begin
               m_pos++;
               m_ack = 1'b0;
            end
         end else begin
            m_ack = 1'b0;
            if (e_fl) begin
               m_pos = 0;
               m_fsw = 1'b1;
            end
         end
         if (e_rg) begin
            m_valid[refill_addr_i] = 1'b1;
            m_tag[refill_addr_i]   = refill_tag_i;
         end
         m_pend = e_lg;
         m_phit = nhit;
         g_rgnt = e_rg;
         g_lgnt = e_lg;
      end
   end

   // Driver tasks are entered and left 1 time unit after a rising edge
   task automatic do_refill(input int a, input int t);
      refill_addr_i = AW'(a);
      refill_tag_i  = TW'(t);
      refill_req_i  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (g_rgnt) begin
            refill_req_i = 1'b0;
            return;
         end
      end
      refill_req_i = 1'b0;
      timeout("refill_wait");
   endtask

   task automatic do_lookup(input int a, input int t, input bit exp_hit);
      bit got;
      got = 1'b0;
      lookup_addr_i = AW'(a);
      lookup_tag_i  = TW'(t);
      lookup_req_i  = 1'b1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(posedge clk); #1;
         got = g_lgnt;
      end
      lookup_req_i = 1'b0;
      if (!got) begin
         timeout("lookup_wait");
      end else begin
         @(negedge clk); #1;
         chk("lk_rvalid", 32'(lookup_rvalid_o), 32'd1);
         chk("lk_hit", 32'(lookup_hit_o), 32'(exp_hit));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int nwr, nack, ackc, g;
      bit hit_20;
      rst_n = 1'b0;
      flush_req_i = 1'b0; lookup_req_i = 1'b0; refill_req_i = 1'b0;
      lookup_addr_i = '0; lookup_tag_i = '0; refill_addr_i = '0; refill_tag_i = '0;
      tag_rdata_i = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = (TW + 1)'($urandom);
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset release: 64 zero writes, lookup held but refused until idle
      lookup_addr_i = 6'd1; lookup_tag_i = '0; lookup_req_i = 1'b1;
      rst_n = 1'b1;
      nwr = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk); #1;
         if (tag_req_o && tag_write_o && tag_addr_o == AW'(i) && tag_wdata_o == '0 &&
             busy_o && !lookup_gnt_o && !flush_ack_o) nwr++;
      end
      chk("init_writes", 32'(nwr), 32'd64);
      @(negedge clk); #1;
      chk("init_done_busy", 32'(busy_o), 32'd0);
      chk("init_no_ack", 32'(flush_ack_o), 32'd0);
      chk("init_first_gnt", 32'(lookup_gnt_o), 32'd1);
      @(posedge clk); #1;
      lookup_req_i = 1'b0;
      @(posedge clk); #1;

      // Refill then lookup two cycles later
      do_refill(5, 'h2A);
      @(posedge clk); #1;
      do_lookup(5, 'h2A, 1'b1);
      do_lookup(5, 'h2B, 1'b0);

      // Back-to-back refill/lookup, with and without a stale SCM read
      do_refill(9, 'h11);
      do_lookup(9, 'h11, 1'b1);
      stale = 1'b1;
      do_refill(9, 'h11);
      do_lookup(9, 'h11, 1'b1);
      do_refill(9, 'h12);
      do_lookup(9, 'h12, 1'b1);

      // Simultaneous refill and lookup: refill wins, lookup next cycle
      refill_addr_i = 6'd12; refill_tag_i = 6'd3; refill_req_i = 1'b1;
      lookup_addr_i = 6'd12; lookup_tag_i = 6'd3; lookup_req_i = 1'b1;
      @(negedge clk); #1;
      chk("both_refill_gnt", 32'(refill_gnt_o), 32'd1);
      chk("both_lookup_gnt", 32'(lookup_gnt_o), 32'd0);
      @(posedge clk); #1;
      refill_req_i = 1'b0;
      @(negedge clk); #1;
      chk("both_lookup_gnt2", 32'(lookup_gnt_o), 32'd1);
      @(posedge clk); #1;
      lookup_req_i = 1'b0;
      @(negedge clk); #1;
      chk("both_rvalid", 32'(lookup_rvalid_o), 32'd1);
      chk("both_hit", 32'(lookup_hit_o), 32'd1);
      @(posedge clk); #1;

      // Fill 0..3, flush with a re-pulse mid-sweep
      for (int i = 0; i < 4; i++) do_refill(i, i + 1);
      @(posedge clk); #1;
      do_lookup(2, 3, 1'b1);
      flush_req_i = 1'b1;
      g = cyc;
      @(posedge clk); #1;
      flush_req_i = 1'b0;
      nack = 0; ackc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (flush_ack_o) begin
            nack++;
            ackc = cyc;
         end
         @(posedge clk); #1;
         flush_req_i = (k == 30);
      end
      flush_req_i = 1'b0;
      chk("flush_ack_count", 32'(nack), 32'd1);
      chk("flush_ack_latency", 32'(ackc - g), 32'd65);
      for (int i = 0; i < 4; i++) do_lookup(i, i + 1, 1'b0);

      // Reset in the middle of a sweep at counter 20
      flush_req_i = 1'b1;
      @(posedge clk); #1;
      flush_req_i = 1'b0;
      hit_20 = 1'b0;
      for (int k = 0; k < 100 && !hit_20; k++) begin
         if (m_pos == 20) hit_20 = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("pre_reset_addr", 32'(tag_addr_o), 32'd20);
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", 32'(tag_req_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_addr", 32'(tag_addr_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("restart_req", 32'(tag_req_o), 32'd1);
      chk("restart_addr", 32'(tag_addr_o), 32'd0);
      chk("restart_busy", 32'(busy_o), 32'd1);
      repeat (70) @(posedge clk);
      #1;

      // Randomized traffic on a small address/tag range, requests held until granted
      for (int n = 0; n < 2500; n++) begin
         if (refill_req_i && g_rgnt) refill_req_i = 1'b0;
         if (lookup_req_i && g_lgnt) lookup_req_i = 1'b0;
         flush_req_i = ($urandom_range(0, 299) == 0);
         if (!refill_req_i && $urandom_range(0, 3) == 0) begin
            refill_req_i  = 1'b1;
            refill_addr_i = AW'($urandom_range(0, 7));
            refill_tag_i  = TW'($urandom_range(0, 3));
         end
         if (!lookup_req_i && $urandom_range(0, 1) == 0) begin
            lookup_req_i  = 1'b1;
            lookup_addr_i = AW'($urandom_range(0, 7));
            lookup_tag_i  = TW'($urandom_range(0, 3));
         end
         @(posedge clk); #1;
      end
      refill_req_i = 1'b0; lookup_req_i = 1'b0; flush_req_i = 1'b0;
      repeat (80) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
